demux4_route: RTL and testbench

DEMUX4_ROUTE -- requirements
Module: demux4_route

---
 rtl/demux4_route.sv | 94 +++++++++
 tb/tb_demux4_route.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/demux4_route.sv
`default_nettype none
// ============================================================================
// Module      : demux4_route
// Description : One-to-four routing demultiplexer with a one-word holding
//               register per channel. A source word offered on in_data is
//               steered to channel in_sel and held there until its sink
//               takes it. A full channel whose sink is stalled back-pressures
//               only words addressed to that channel. A full channel that is
//               being drained in the same cycle can accept a new word, so a
//               continuous stream sustains one word per cycle per channel.
//
// Ports       : clk        - clock, all state updates on the rising edge
//               rst_n      - asynchronous active-low reset
//               in_data    - 32-bit source word
//               in_sel     - destination channel 0..3 (used while in_valid=1)
//               in_valid   - source offers a word
//               in_ready   - block accepts the offered word this cycle
//               out_data0..3 - per-channel holding register contents
//               out_valid  - bit k: channel k holds an undelivered word
//               out_ready  - bit k: sink k takes its word this cycle
//               xfer_cnt   - wrapping count of accepted source words
//
// Revision    : 1.0 - initial release
// ============================================================================
module demux4_route (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_sel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data0,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic [31:0] out_data3,
  output logic [3:0]  out_valid,
  input  logic [3:0]  out_ready,
  output logic [15:0] xfer_cnt
);

  logic [3:0][31:0] data_q;
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic             w_accept;
  logic [3:0]       w_load;

  // A channel can take a word when it is empty or when its current word
  // leaves this cycle. Deliberately independent of in_valid.
  assign in_ready = !valid_q[in_sel] | out_ready[in_sel];
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load  = 4'b0000;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (w_accept) begin
      w_load[in_sel] = 1'b1;
      cnt_d          = cnt_q + 16'd1;
    end
    // A load wins over a pop on the same channel, keeping the flag set;
    // out_ready on an empty channel is harmless because it only clears.
    for (int k = 0; k < 4; k++) begin
      valid_d[k] = w_load[k] | (valid_q[k] & ~out_ready[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 4'b0000;
      cnt_q   <= 16'h0000;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      // Data is only written on a load; a pop leaves the last word visible.
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          data_q[k] <= in_data;
        end
      end
    end
  end

  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign out_valid = valid_q;
  assign xfer_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_demux4_route.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux4_route
// Description : Directed self-checking bench for demux4_route. Inputs are
//               driven 1 time unit after a rising edge; outputs are checked
//               just before/after edges, never on them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4_route;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic [31:0] out_data3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] xfer_cnt;

  int total;
  int bad;

  demux4_route dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle 1 time unit.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_data   = 32'h0;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;

    // Reset state, including in_ready=1 while held in reset.
    #2;
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'hAAAA5555;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("rst_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("rst_d1", out_data1, 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Single accept to channel 2.
    step();
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 32'hDEADBEEF;
    step();
    in_valid = 1'b0;
    chk("c2_valid", {28'd0, out_valid}, 32'h4);
    chk("c2_data", out_data2, 32'hDEADBEEF);
    chk("c2_cnt", {16'd0, xfer_cnt}, 32'd1);

    // Fill channel 1, then a stalled second word must be refused.
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'h11111111;
    step();
    in_data  = 32'h99999999;
    #1;
    chk("c1_full_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("c1_hold", out_data1, 32'h11111111);
    chk("c1_cnt", {16'd0, xfer_cnt}, 32'd2);
    // A different channel is not blocked by the stalled one.
    in_sel  = 2'd3;
    in_data = 32'h33333333;
    #1;
    chk("c3_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("c3_valid", {28'd0, out_valid}, 32'hE);
    chk("c3_data", out_data3, 32'h33333333);

    // Pop channel 2 alone: flag clears, data retained.
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;
    chk("pop2_valid", {28'd0, out_valid}, 32'hA);
    chk("pop2_data", out_data2, 32'hDEADBEEF);

    // Fill channel 0, then stream 1..5 while draining it every cycle.
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 32'd0;
    step();
    out_ready = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      in_data = i;
      #1;
      chk("strm_ready", {31'd0, in_ready}, 32'd1);
      step();
      chk("strm_valid0", {31'd0, out_valid[0]}, 32'd1);
      chk("strm_data0", out_data0, i);
    end
    out_ready = 4'b0000;
    chk("strm_cnt", {16'd0, xfer_cnt}, 32'd9);

    // Fill channel 2 again so all four are full, then reset mid-cycle.
    in_sel  = 2'd2;
    in_data = 32'h22222222;
    step();
    in_valid = 1'b0;
    chk("full_valid", {28'd0, out_valid}, 32'hF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {28'd0, out_valid}, 32'd0);
    chk("mrst_d0", out_data0, 32'd0);
    chk("mrst_d1", out_data1, 32'd0);
    chk("mrst_d2", out_data2, 32'd0);
    chk("mrst_d3", out_data3, 32'd0);
    chk("mrst_cnt", {16'd0, xfer_cnt}, 32'd0);
    step();
    rst_n = 1'b1;

    // Idle inputs with toggling select and ready sinks: nothing changes.
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      in_sel  = i[1:0];
      in_data = 32'hC0DE0000 + i;
      step();
    end
    chk("idle_valid", {28'd0, out_valid}, 32'd0);
    chk("idle_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("idle_d0", out_data0, 32'd0);

    // First edge after reset operates normally, then run the counter to wrap.
    out_ready = 4'b0001;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    for (int i = 0; i < 65535; i++) begin
      in_data = i;
      step();
    end
    chk("cnt_ffff", {16'd0, xfer_cnt}, 32'hFFFF);
    chk("cnt_d0", out_data0, 32'd65534);
    step();
    in_valid = 1'b0;
    chk("cnt_wrap", {16'd0, xfer_cnt}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
